// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } pipe_state_e;

  localparam int unsigned DEF_INIT_CYCLES = 2;
  localparam int unsigned DEF_TIMEOUT     = 256;

  // Counter width able to hold 0..limit-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/pipe_wait_timer.sv
// Clearable up-counter with a terminal-count flag at LIMIT-1.
// Holds at LIMIT-1 rather than wrapping, so tc stays asserted until cleared.
module pipe_wait_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = 2,
  parameter int unsigned W     = cnt_width(LIMIT)
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  // Count enabled cycles; clear has priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Optional feature macro: PIPE_PERF_CNT_EN adds stall_cnt / flush_cnt.
//
// state       | meaning
// ST_INIT     | post-reset drain, every stage flushed
// ST_RUN      | normal issue, Mealy priority of wait/redirect/stall/fetch
// ST_MEM_WAIT | data access outstanding, pipeline frozen, watchdog counting
// ST_HALT     | bus hang detected, everything frozen until reset
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             hz_stall,
  input  logic             ex_redirect,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             bus_err
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  if (TIMEOUT < 2 || CNT_W < 1) begin : g_bad_param
    $error("pipeline_ctrl: TIMEOUT must be >= 2 and CNT_W >= 1");
  end

  pipe_state_e state, next_state;
  logic        init_tc, wait_tc;
  logic        wait_cycle;
  logic        redirect_taken;

  // The RUN cycle that first sees the miss is already wait cycle one, so the
  // watchdog counts it too; HALT then follows exactly TIMEOUT frozen cycles.
  pipe_wait_timer #(.LIMIT(INIT_CYCLES)) u_init_timer (
    .clk  (clk),
    .rstn (rstn),
    .clr  (state != ST_INIT),
    .en   (state == ST_INIT),
    .tc   (init_tc)
  );

  pipe_wait_timer #(.LIMIT(TIMEOUT)) u_wait_timer (
    .clk  (clk),
    .rstn (rstn),
    .clr  (!wait_cycle),
    .en   (wait_cycle),
    .tc   (wait_tc)
  );

  // Mealy outputs and next state from the current state and this cycle's inputs.
  always_comb begin
    pc_en          = 1'b0;
    if_id_en       = 1'b0;
    id_ex_en       = 1'b0;
    ex_mem_en      = 1'b0;
    mem_wb_en      = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    mem_wb_flush   = 1'b0;
    wait_cycle     = 1'b0;
    redirect_taken = 1'b0;
    next_state     = state;
    case (state)
      ST_INIT: begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        mem_wb_flush = 1'b1;
        if (init_tc) next_state = ST_RUN;
      end
      ST_RUN, ST_MEM_WAIT: begin
        // A frozen MEM instruction keeps its request, so only ready matters once waiting.
        wait_cycle = (state == ST_RUN) ? (dmem_req && !dmem_ready) : !dmem_ready;
        if (wait_cycle) begin
          mem_wb_flush = 1'b1;
          if (state == ST_MEM_WAIT && wait_tc) next_state = ST_HALT;
          else                                 next_state = ST_MEM_WAIT;
        end else begin
          next_state = ST_RUN;
          pc_en      = 1'b1;
          if_id_en   = 1'b1;
          id_ex_en   = 1'b1;
          ex_mem_en  = 1'b1;
          mem_wb_en  = 1'b1;
          if (ex_redirect) begin
            // Redirect wins over a load-use stall: the stalled instruction is wrong-path.
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            redirect_taken = 1'b1;
          end else if (hz_stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (!imem_ready) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // State register and sticky bus error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_INIT;
      bus_err <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_MEM_WAIT && next_state == ST_HALT) bus_err <= 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Performance counters, frozen outside RUN/MEM_WAIT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state == ST_RUN || state == ST_MEM_WAIT) begin
      if (!pc_en)         stall_cnt <= stall_cnt + 1'b1;
      if (redirect_taken) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl (INIT_CYCLES=2, TIMEOUT=8).
// Output vector order: {pc, if_id, id_ex, ex_mem, mem_wb, f_if_id, f_id_ex, f_mem_wb}.
module tb_pipeline_ctrl;

  localparam int unsigned INIT_CYCLES = 2;
  localparam int unsigned TIMEOUT     = 8;

  logic clk = 1'b0;
  logic rstn, hz_stall, ex_redirect, imem_ready, dmem_req, dmem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush, bus_err;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipeline_ctrl #(.INIT_CYCLES(INIT_CYCLES), .TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .hz_stall     (hz_stall),
    .ex_redirect  (ex_redirect),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_en     (id_ex_en),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_en    (mem_wb_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .mem_wb_flush (mem_wb_flush),
    .bus_err      (bus_err)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] dut_out();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_flush, id_ex_flush, mem_wb_flush};
  endfunction

  // Reference model: cycles of drain remaining, consecutive wait cycles, halt flag.
  int          m_init_left;
  bit          m_waiting;
  int          m_wait_n;
  bit          m_halt;
  bit          m_bus_err;
  logic [31:0] m_stall, m_flush;

  function automatic bit model_wait_now();
    return m_waiting ? !dmem_ready : (dmem_req && !dmem_ready);
  endfunction

  function automatic logic [7:0] model_out();
    if (!rstn || m_init_left > 0) return 8'b00000111;
    if (m_halt)                   return 8'b00000000;
    if (model_wait_now())         return 8'b00000001;
    if (ex_redirect)              return 8'b11111110;
    if (hz_stall)                 return 8'b00111010;
    if (!imem_ready)              return 8'b01111100;
    return 8'b11111000;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_init_left = INIT_CYCLES;
      m_waiting   = 0;
      m_wait_n    = 0;
      m_halt      = 0;
      m_bus_err   = 0;
      m_stall     = '0;
      m_flush     = '0;
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else if (!m_halt) begin
      logic [7:0] o;
      bit         w;
      o = model_out();
      w = model_wait_now();
      if (!o[7]) m_stall++;
      if (!w && ex_redirect) m_flush++;
      if (w) begin
        m_wait_n++;
        if (m_wait_n >= TIMEOUT) begin
          m_halt    = 1;
          m_bus_err = 1;
        end else begin
          m_waiting = 1;
        end
      end else begin
        m_waiting = 0;
        m_wait_n  = 0;
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("outs", {24'd0, dut_out()}, {24'd0, model_out()});
    check("bus_err", {31'd0, bus_err}, {31'd0, m_bus_err});
`ifdef PIPE_PERF_CNT_EN
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit hz, input bit rd, input bit im, input bit rq, input bit dr);
    hz_stall    = hz;
    ex_redirect = rd;
    imem_ready  = im;
    dmem_req    = rq;
    dmem_ready  = dr;
  endtask

  task automatic expect_out(input string name, input logic [7:0] exp);
    #1;
    check(name, {24'd0, dut_out()}, {24'd0, exp});
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    set_in(0, 0, 1, 0, 0);
    step();
    step();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    set_in(0, 0, 1, 0, 0);
    #2;
    expect_out("reset_outs", 8'b00000111);
    check("reset_bus_err", {31'd0, bus_err}, 32'd0);
    step();
    step();
    rstn = 1'b1;
    expect_out("drain0", 8'b00000111);
    step();
    expect_out("drain1", 8'b00000111);
    step();
    expect_out("run", 8'b11111000);

    // Single load-use stall, then free flow.
    set_in(1, 0, 1, 0, 0);
    expect_out("hz_stall", 8'b00111010);
    step();
    set_in(0, 0, 1, 0, 0);
    expect_out("after_stall", 8'b11111000);
    step();

    // Redirect beats a simultaneous stall.
    set_in(1, 1, 1, 0, 0);
    expect_out("redirect_over_stall", 8'b11111110);
    step();
    set_in(0, 0, 0, 0, 0);
    expect_out("imem_not_ready", 8'b01111100);
    step();

    // Three-cycle data wait with a redirect held in EX.
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 1, 1, 0);
      expect_out("dmem_freeze", 8'b00000001);
      step();
    end
    set_in(0, 1, 1, 1, 1);
    expect_out("dmem_release_redirect", 8'b11111110);
    step();
    set_in(0, 0, 1, 1, 1);
    expect_out("dmem_ready_no_wait", 8'b11111000);
    step();

    // Watchdog: TIMEOUT frozen cycles, then HALT.
    do_reset();
    step();
    step();
    set_in(0, 0, 1, 1, 0);
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      expect_out("wd_frozen", 8'b00000001);
      check("wd_no_err_yet", {31'd0, bus_err}, 32'd0);
      step();
    end
    expect_out("halt_outs", 8'b00000000);
    check("halt_bus_err", {31'd0, bus_err}, 32'd1);
    set_in(0, 1, 1, 1, 1);
    step();
    step();
    expect_out("halt_held", 8'b00000000);
    check("halt_bus_err_sticky", {31'd0, bus_err}, 32'd1);
    rstn = 1'b0;
    expect_out("halt_reset_outs", 8'b00000111);
    check("halt_reset_bus_err", {31'd0, bus_err}, 32'd0);
    step();
    rstn = 1'b1;

`ifdef PIPE_PERF_CNT_EN
    // Two load-use stalls and one redirect.
    do_reset();
    step();
    step();
    set_in(1, 0, 1, 0, 0); step();
    set_in(0, 0, 1, 0, 0); step();
    set_in(1, 0, 1, 0, 0); step();
    set_in(0, 1, 1, 0, 0); step();
    set_in(0, 0, 1, 0, 0); step();
    #1;
    check("perf_stall", stall_cnt, 32'd2);
    check("perf_flush", flush_cnt, 32'd1);
`endif

    // Randomized traffic with occasional asynchronous resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 9) < 6);
      if ($urandom_range(0, 299) == 0) begin
        #2 rstn = 1'b0;
        step();
        rstn = 1'b1;
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
